awg_cmd_ctrl: RTL and testbench

Configuration controller for the AWG. Parses the ASCII byte stream from the UART receiver into multi-digit commands and range-checks each argument. Commits accepted values atomically to the waveform-select, frequency, amplitude and phase registers consumed by the waveform datapath. Keeps single-key '0'-'4' waveform selection for existing host scripts.

---
 rtl/awg_pkg.sv | 45 ++++
 rtl/awg_cmd_ctrl_if.sv | 26 ++
 rtl/awg_dec_acc.sv | 46 ++++
 rtl/awg_cmd_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_awg_cmd_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/awg_pkg.sv
// Shared constants, encodings and byte classifiers for the AWG command controller.
package awg_pkg;

  localparam int unsigned STATE_W    = 5;
  localparam int unsigned FREQ_W     = 12;
  localparam int unsigned AMP_W      = 3;
  localparam int unsigned PHASE_W    = 8;
  localparam int unsigned ACC_W      = 17;
  localparam int unsigned CNT_W      = 3;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned MAX_DIGITS = 5;

  localparam int unsigned FREQ_MAX   = 4095;
  localparam int unsigned AMP_MAX    = 7;
  localparam int unsigned PHASE_MAX  = 255;
  localparam int unsigned STATE_MAX  = 3;
  localparam int unsigned STATE_ALT  = 10;

  localparam logic [STATE_W-1:0] DEF_STATE  = 5'd3;
  localparam logic [FREQ_W-1:0]  DEF_FREQ   = 12'd1;
  localparam logic [AMP_W-1:0]   DEF_AMP    = 3'd2;
  localparam logic [PHASE_W-1:0] DEF_PHASE  = 8'd50;
  localparam logic [FREQ_W-1:0]  SWEEP_STEP = 12'd100;

  localparam logic [7:0] CHR_W  = 8'h57;
  localparam logic [7:0] CHR_F  = 8'h46;
  localparam logic [7:0] CHR_A  = 8'h41;
  localparam logic [7:0] CHR_P  = 8'h50;
  localparam logic [7:0] CHR_S  = 8'h53;
  localparam logic [7:0] CHR_CR = 8'h0D;
  localparam logic [7:0] CHR_LF = 8'h0A;
  localparam logic [7:0] CHR_0  = 8'h30;

  typedef enum logic [1:0] {IDLE, GET_ARG, COMMIT, ERR_FLUSH} fsm_e;
  typedef enum logic [2:0] {TGT_W, TGT_F, TGT_A, TGT_P, TGT_S} tgt_e;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CHR_0) && (b <= CHR_0 + 8'd9);
  endfunction

  function automatic logic is_eol(input logic [7:0] b);
    return (b == CHR_CR) || (b == CHR_LF);
  endfunction

endpackage

// File: rtl/awg_cmd_ctrl_if.sv
// UART byte input and config-register output bundle of the AWG command controller.
interface awg_cmd_ctrl_if;
  import awg_pkg::*;

  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               sweep_tick;
  logic [STATE_W-1:0] state;
  logic [FREQ_W-1:0]  state_freq;
  logic [AMP_W-1:0]   state_amp;
  logic [PHASE_W-1:0] state_phase;
  logic               cfg_upd;
  logic               cmd_err;
  logic               busy;

  modport master (
    output rx_data, rx_valid, sweep_tick,
    input  state, state_freq, state_amp, state_phase, cfg_upd, cmd_err, busy
  );

  modport slave (
    input  rx_data, rx_valid, sweep_tick,
    output state, state_freq, state_amp, state_phase, cfg_upd, cmd_err, busy
  );

endinterface

// File: rtl/awg_dec_acc.sv
// Decimal argument accumulator: clear, digit load (acc*10+d), digit count, overflow flag.
module awg_dec_acc
  import awg_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               load_i,
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [ACC_W-1:0]   acc_o,
  output logic [CNT_W-1:0]   cnt_o,
  output logic               full_c
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign full_c = (cnt_q == CNT_W'(MAX_DIGITS));

  // acc*10 built from shifts; with at most MAX_DIGITS digits the result fits in ACC_W
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (load_i && !full_c) begin
      acc_d = (acc_q << 3) + (acc_q << 1) + ACC_W'(digit_i);
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc_o = acc_q;
  assign cnt_o = cnt_q;

endmodule

// File: rtl/awg_cmd_ctrl.sv
// AWG command parser: multi-digit W/F/A/P commands, legacy '0'-'4' keys, atomic config commit.
// Optional frequency sweep ('S' command, sweep_tick) is built when AWG_SWEEP_EN is defined.
module awg_cmd_ctrl
  import awg_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  awg_cmd_ctrl_if.slave  bus
);

  fsm_e               fsm_q, fsm_d;
  tgt_e               tgt_q, tgt_d;
  logic [STATE_W-1:0] wave_q, wave_d;
  logic [FREQ_W-1:0]  freq_q, freq_d;
  logic [AMP_W-1:0]   amp_q, amp_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               cfg_upd_q, cfg_upd_d;
  logic               cmd_err_q, cmd_err_d;
  logic               busy_q, busy_d;

  logic               acc_clr, acc_load, acc_full, commit_ok;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic [DIGIT_W-1:0] digit_c;
  logic [2:0]         key_c;
  logic               legacy_c;

`ifdef AWG_SWEEP_EN
  logic               sweep_en_q, sweep_en_d;
  logic [FREQ_W:0]    sweep_sum_c;
  assign sweep_sum_c = {1'b0, freq_q} + {1'b0, SWEEP_STEP};
`else
  logic               unused_tick;
  assign unused_tick = bus.sweep_tick;
`endif

  assign digit_c  = DIGIT_W'(bus.rx_data - CHR_0);
  assign key_c    = bus.rx_data[2:0];
  assign legacy_c = (bus.rx_data >= CHR_0) && (bus.rx_data <= CHR_0 + 8'd4);

  awg_dec_acc u_acc (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (acc_clr),
    .load_i  (acc_load),
    .digit_i (digit_c),
    .acc_o   (acc),
    .cnt_o   (cnt),
    .full_c  (acc_full)
  );

  // Range check of the accumulated argument for the latched target
  always_comb begin
    commit_ok = 1'b0;
    unique case (tgt_q)
      TGT_W: commit_ok = (acc <= ACC_W'(STATE_MAX)) || (acc == ACC_W'(STATE_ALT));
      TGT_F: commit_ok = (acc >= ACC_W'(1)) && (acc <= ACC_W'(FREQ_MAX));
      TGT_A: commit_ok = (acc <= ACC_W'(AMP_MAX));
      TGT_P: commit_ok = (acc <= ACC_W'(PHASE_MAX));
`ifdef AWG_SWEEP_EN
      TGT_S: commit_ok = (acc <= ACC_W'(1)) && (cnt == CNT_W'(1));
`endif
      default: commit_ok = 1'b0;
    endcase
  end

  always_comb begin
    fsm_d     = fsm_q;
    tgt_d     = tgt_q;
    wave_d    = wave_q;
    freq_d    = freq_q;
    amp_d     = amp_q;
    phase_d   = phase_q;
    cfg_upd_d = 1'b0;
    cmd_err_d = 1'b0;
    acc_clr   = 1'b0;
    acc_load  = 1'b0;
`ifdef AWG_SWEEP_EN
    sweep_en_d = sweep_en_q;
`endif

    unique case (fsm_q)
      IDLE: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == CHR_W) begin
            tgt_d = TGT_W; acc_clr = 1'b1; fsm_d = GET_ARG;
          end else if (bus.rx_data == CHR_F) begin
            tgt_d = TGT_F; acc_clr = 1'b1; fsm_d = GET_ARG;
          end else if (bus.rx_data == CHR_A) begin
            tgt_d = TGT_A; acc_clr = 1'b1; fsm_d = GET_ARG;
          end else if (bus.rx_data == CHR_P) begin
            tgt_d = TGT_P; acc_clr = 1'b1; fsm_d = GET_ARG;
`ifdef AWG_SWEEP_EN
          end else if (bus.rx_data == CHR_S) begin
            tgt_d = TGT_S; acc_clr = 1'b1; fsm_d = GET_ARG;
`endif
          end else if (legacy_c) begin
            // '0' selects the alternate waveform, '1'..'4' map to 0..3
            wave_d    = (key_c == 3'd0) ? STATE_W'(STATE_ALT) : STATE_W'(key_c - 3'd1);
            cfg_upd_d = 1'b1;
          end
        end
      end
      GET_ARG: begin
        if (bus.rx_valid) begin
          if (is_digit(bus.rx_data)) begin
            if (acc_full) fsm_d = ERR_FLUSH;
            else          acc_load = 1'b1;
          end else if (is_eol(bus.rx_data)) begin
            if (cnt == '0) begin
              cmd_err_d = 1'b1;
              fsm_d     = IDLE;
            end else begin
              fsm_d = COMMIT;
            end
          end else begin
            fsm_d = ERR_FLUSH;
          end
        end
      end
      COMMIT: begin
        fsm_d = IDLE;
        if (commit_ok) begin
          unique case (tgt_q)
            TGT_W:   begin wave_d  = STATE_W'(acc); cfg_upd_d = 1'b1; end
            TGT_F:   begin freq_d  = FREQ_W'(acc);  cfg_upd_d = 1'b1; end
            TGT_A:   begin amp_d   = AMP_W'(acc);   cfg_upd_d = 1'b1; end
            TGT_P:   begin phase_d = PHASE_W'(acc); cfg_upd_d = 1'b1; end
`ifdef AWG_SWEEP_EN
            TGT_S:   sweep_en_d = acc[0];
`endif
            default: ;
          endcase
        end else begin
          cmd_err_d = 1'b1;
        end
      end
      ERR_FLUSH: begin
        if (bus.rx_valid && is_eol(bus.rx_data)) begin
          cmd_err_d = 1'b1;
          fsm_d     = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase

`ifdef AWG_SWEEP_EN
    // A tick loses to an F commit and is dropped in a cycle raising cmd_err
    if (bus.sweep_tick && sweep_en_q && !cmd_err_d &&
        !(fsm_q == COMMIT && tgt_q == TGT_F && commit_ok)) begin
      freq_d    = (sweep_sum_c > (FREQ_W+1)'(FREQ_MAX)) ? DEF_FREQ : FREQ_W'(sweep_sum_c);
      cfg_upd_d = 1'b1;
    end
`endif

    busy_d = (fsm_d == COMMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= IDLE;
      tgt_q     <= TGT_W;
      wave_q    <= DEF_STATE;
      freq_q    <= DEF_FREQ;
      amp_q     <= DEF_AMP;
      phase_q   <= DEF_PHASE;
      cfg_upd_q <= 1'b0;
      cmd_err_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef AWG_SWEEP_EN
      sweep_en_q <= 1'b0;
`endif
    end else begin
      fsm_q     <= fsm_d;
      tgt_q     <= tgt_d;
      wave_q    <= wave_d;
      freq_q    <= freq_d;
      amp_q     <= amp_d;
      phase_q   <= phase_d;
      cfg_upd_q <= cfg_upd_d;
      cmd_err_q <= cmd_err_d;
      busy_q    <= busy_d;
`ifdef AWG_SWEEP_EN
      sweep_en_q <= sweep_en_d;
`endif
    end
  end

  assign bus.state       = wave_q;
  assign bus.state_freq  = freq_q;
  assign bus.state_amp   = amp_q;
  assign bus.state_phase = phase_q;
  assign bus.cfg_upd     = cfg_upd_q;
  assign bus.cmd_err     = cmd_err_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_awg_cmd_ctrl.sv
// Directed bench for awg_cmd_ctrl: command vector table plus latency, drop, sweep and reset sequences.
module tb_awg_cmd_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   upd_cnt;
  int   err_cnt;
  int   u0;
  int   e0;

  awg_cmd_ctrl_if bus ();

  awg_cmd_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] cmd;
    int          len;
    int          st;
    int          fr;
    int          am;
    int          ph;
    int          upd;
    int          err;
  } vec_t;

  vec_t vecs[24];
  int   nv;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the next negedge after the byte was sampled
  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [63:0] c, input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = c[8*(n-1-i) +: 8];
      send_byte(b);
    end
  endtask

  task automatic tick();
    bus.sweep_tick = 1'b1;
    @(negedge clk);
    bus.sweep_tick = 1'b0;
  endtask

  task automatic add_vec(input logic [63:0] c, input int n, input int st, input int fr,
                         input int am, input int ph, input int upd, input int err);
    vecs[nv].cmd = c;   vecs[nv].len = n;
    vecs[nv].st  = st;  vecs[nv].fr  = fr;
    vecs[nv].am  = am;  vecs[nv].ph  = ph;
    vecs[nv].upd = upd; vecs[nv].err = err;
    nv++;
  endtask

  task automatic check_cfg(input string tag, input int st, input int fr, input int am, input int ph);
    check({tag, " state"}, int'(bus.state), st);
    check({tag, " freq"},  int'(bus.state_freq), fr);
    check({tag, " amp"},   int'(bus.state_amp), am);
    check({tag, " phase"}, int'(bus.state_phase), ph);
  endtask

  task automatic check_pulses(input string tag, input int upd, input int err);
    check({tag, " upd_pulses"}, upd_cnt - u0, upd);
    check({tag, " err_pulses"}, err_cnt - e0, err);
  endtask

  // Pulse counter and mutual-exclusion check of cfg_upd/cmd_err
  always @(posedge clk) begin
    if (!rst) begin
      if (bus.cfg_upd) upd_cnt++;
      if (bus.cmd_err) err_cnt++;
      if (bus.cfg_upd || bus.cmd_err) begin
        n_cmp++;
        if (bus.cfg_upd && bus.cmd_err) begin
          n_bad++;
          $display("FAIL pulse_excl: cfg_upd=%0b cmd_err=%0b at %0t, required not both", bus.cfg_upd, bus.cmd_err, $time);
        end
      end
    end
  end

  initial begin
    n_cmp = 0; n_bad = 0; upd_cnt = 0; err_cnt = 0; nv = 0;
    rst = 1'b1;
    bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.sweep_tick = 1'b0;

    // Commands run in order; expectations accumulate from state (3,1234,2,50)
    add_vec("A9\r",      3,  3, 1234, 2,  50, 0, 1);
    add_vec("W5\r",      3,  3, 1234, 2,  50, 0, 1);
    add_vec("F0\r",      3,  3, 1234, 2,  50, 0, 1);
    add_vec("F123456\r", 8,  3, 1234, 2,  50, 0, 1);
    add_vec("P200\n",    5,  3, 1234, 2, 200, 1, 0);
    add_vec("0",         1, 10, 1234, 2, 200, 1, 0);
    add_vec("2",         1,  1, 1234, 2, 200, 1, 0);
    add_vec("A7\r",      3,  1, 1234, 7, 200, 1, 0);
    add_vec("F4095\r",   6,  1, 4095, 7, 200, 1, 0);
    add_vec("F4096\r",   6,  1, 4095, 7, 200, 0, 1);
    add_vec("W10\r",     4, 10, 4095, 7, 200, 1, 0);
    add_vec("P256\r",    5, 10, 4095, 7, 200, 0, 1);
    add_vec("\r",        1, 10, 4095, 7, 200, 0, 0);
    add_vec("F\r",       2, 10, 4095, 7, 200, 0, 1);
    add_vec("FX\r",      3, 10, 4095, 7, 200, 0, 1);
    add_vec("f4\r",      3,  3, 4095, 7, 200, 1, 0);
    add_vec("P0\r",      3,  3, 4095, 7,   0, 1, 0);
    add_vec("W00002\r",  7,  2, 4095, 7,   0, 1, 0);
    add_vec("A0\r",      3,  2, 4095, 0,   0, 1, 0);
    add_vec("F1\r",      3,  2,    1, 0,   0, 1, 0);
    add_vec("W4\r",      3,  2,    1, 0,   0, 0, 1);

    repeat (3) @(negedge clk);
    check_cfg("reset", 3, 1, 2, 50);
    check("reset cfg_upd", int'(bus.cfg_upd), 0);
    check("reset cmd_err", int'(bus.cmd_err), 0);
    check("reset busy",    int'(bus.busy), 0);
    rst = 1'b0;
    idle(2);

    // Commit latency: register and cfg_upd appear one cycle after the terminator
    u0 = upd_cnt; e0 = err_cnt;
    send_bytes("F1234\r", 6);
    check("lat commit freq_old", int'(bus.state_freq), 1);
    check("lat commit busy",     int'(bus.busy), 1);
    check("lat commit upd_early", int'(bus.cfg_upd), 0);
    @(negedge clk);
    check("lat freq_new", int'(bus.state_freq), 1234);
    check("lat cfg_upd",  int'(bus.cfg_upd), 1);
    check("lat busy_low", int'(bus.busy), 0);
    idle(3);
    check_pulses("lat", 1, 0);

    for (int i = 0; i < nv; i++) begin
      u0 = upd_cnt; e0 = err_cnt;
      send_bytes(vecs[i].cmd, vecs[i].len);
      idle(3);
      check_cfg($sformatf("vec%0d", i), vecs[i].st, vecs[i].fr, vecs[i].am, vecs[i].ph);
      check_pulses($sformatf("vec%0d", i), vecs[i].upd, vecs[i].err);
    end

    // '3' lands in the COMMIT cycle and must be dropped, not taken as a legacy key
    u0 = upd_cnt; e0 = err_cnt;
    send_bytes("A5\r3", 4);
    idle(3);
    check_cfg("drop", 2, 1, 5, 0);
    check_pulses("drop", 1, 0);

`ifdef AWG_SWEEP_EN
    send_bytes("F4000\r", 6);
    idle(3);
    u0 = upd_cnt; e0 = err_cnt;
    send_bytes("S1\r", 3);
    idle(3);
    check_pulses("sweep_en", 0, 0);
    tick();
    check("sweep wrap freq", int'(bus.state_freq), 1);
    check("sweep wrap upd",  int'(bus.cfg_upd), 1);
    tick();
    check("sweep step freq", int'(bus.state_freq), 101);
    idle(3);
    u0 = upd_cnt; e0 = err_cnt;
    send_bytes("F77\r", 4);
    tick();
    check("sweep coincide freq", int'(bus.state_freq), 77);
    idle(3);
    check("sweep coincide hold", int'(bus.state_freq), 77);
    check_pulses("sweep coincide", 1, 0);
    send_bytes("S0\r", 3);
    idle(2);
    u0 = upd_cnt;
    tick();
    idle(3);
    check("sweep off freq", int'(bus.state_freq), 77);
    check("sweep off upd",  upd_cnt - u0, 0);
    u0 = upd_cnt; e0 = err_cnt;
    send_bytes("S2\r", 3);
    idle(3);
    check_pulses("sweep bad arg", 0, 1);
    send_bytes("S1\r", 3);
    idle(3);
`else
    u0 = upd_cnt; e0 = err_cnt;
    tick();
    idle(3);
    check("tick ignored freq", int'(bus.state_freq), 1);
    check_pulses("tick ignored", 0, 0);
    send_bytes("S1\r", 3);
    idle(3);
    check("S ignored legacy", int'(bus.state), 0);
`endif

    // Reset mid-command discards the partial "F99"
    send_bytes("F99", 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_cfg("midreset", 3, 1, 2, 50);
    u0 = upd_cnt; e0 = err_cnt;
    send_bytes("\r", 1);
    idle(3);
    check("midreset freq", int'(bus.state_freq), 1);
    check_pulses("midreset", 0, 0);
    u0 = upd_cnt;
    tick();
    idle(3);
    check("postreset tick freq", int'(bus.state_freq), 1);
    check("postreset tick upd",  upd_cnt - u0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
